// File: rtl/hs_to_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : hs_to_stream_adapter
//  Description : Converts an ap_hs word handshake into an AXI-Stream master.
//                Words pass through a 2-entry FIFO. A small packet tracker
//                reads each header's length field and marks the final beat
//                of every packet with tlast.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_to_stream_adapter #(
    parameter logic [7:0] ACC_ID  = 8'h00,
    parameter int         LEN_LSB = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_hs,
    input  logic        in_hs_ap_vld,
    output logic        in_hs_ap_ack,
    output logic [63:0] outStream_tdata,
    output logic        outStream_tvalid,
    input  logic        outStream_tready,
    output logic        outStream_tlast,
    output logic [7:0]  outStream_tid,
    output logic        busy
);

    typedef enum logic [0:0] {
        HEADER  = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [1:0] c_DEPTH = 2'd2;

    logic [63:0] r_data [2];
    logic        r_last [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    state_t      r_state;
    logic [7:0]  r_remaining;

    logic        w_push;
    logic        w_pop;
    logic        w_push_last;
    logic [7:0]  w_len;

    assign w_len  = in_hs[LEN_LSB +: 8];
    assign w_push = in_hs_ap_vld && in_hs_ap_ack;
    assign w_pop  = outStream_tvalid && outStream_tready;

    always_comb begin
        w_push_last = 1'b0;
        if (r_state == HEADER) begin
            w_push_last = (w_len == 8'd0);
        end else begin
            w_push_last = (r_remaining == 8'd1);
        end
    end

    // Storage and pointers; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= in_hs;
                r_last[r_wr_ptr] <= w_push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Packet tracker advances only on accepted input words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HEADER;
            r_remaining <= 8'd0;
        end else if (w_push) begin
            case (r_state)
                HEADER: begin
                    if (w_len != 8'd0) begin
                        r_remaining <= w_len;
                        r_state     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    r_remaining <= r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        r_state <= HEADER;
                    end
                end
                default: begin
                    r_state     <= HEADER;
                    r_remaining <= 8'd0;
                end
            endcase
        end
    end

    assign in_hs_ap_ack     = !rst && (r_count < c_DEPTH);
    assign outStream_tvalid = (r_count != 2'd0);
    assign outStream_tdata  = r_data[r_rd_ptr];
    // Gated so a stale head entry never shows tlast while idle.
    assign outStream_tlast  = outStream_tvalid && r_last[r_rd_ptr];
    assign outStream_tid    = ACC_ID;
    assign busy             = (r_state == PAYLOAD) || (r_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_hs_to_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hs_to_stream_adapter
//  Description : Directed scoreboard bench for hs_to_stream_adapter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_to_stream_adapter;

    localparam logic [7:0] c_ACC_ID = 8'h5A;

    logic        clk;
    logic        rst;
    logic [63:0] in_hs;
    logic        in_hs_ap_vld;
    logic        in_hs_ap_ack;
    logic [63:0] outStream_tdata;
    logic        outStream_tvalid;
    logic        outStream_tready;
    logic        outStream_tlast;
    logic [7:0]  outStream_tid;
    logic        busy;

    hs_to_stream_adapter #(
        .ACC_ID  (c_ACC_ID),
        .LEN_LSB (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_hs            (in_hs),
        .in_hs_ap_vld     (in_hs_ap_vld),
        .in_hs_ap_ack     (in_hs_ap_ack),
        .outStream_tdata  (outStream_tdata),
        .outStream_tvalid (outStream_tvalid),
        .outStream_tready (outStream_tready),
        .outStream_tlast  (outStream_tlast),
        .outStream_tid    (outStream_tid),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: occupancy, packet state and expected beats.
    logic [64:0] q[$];
    int          m_count     = 0;
    bit          m_payload   = 0;
    int          m_rem       = 0;
    bit          mon_en      = 0;
    int          n_beats     = 0;
    int          n_last      = 0;
    int          pkt_beats   = 0;
    int          last_pkt_sz = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_ack, exp_valid, push, pop, lst;
            exp_ack   = !rst && (m_count < 2);
            exp_valid = (m_count != 0);
            check("ack",   64'(in_hs_ap_ack),     64'(exp_ack));
            check("valid", 64'(outStream_tvalid), 64'(exp_valid));
            check("busy",  64'(busy),             64'(m_payload || m_count != 0));
            check("tid",   64'(outStream_tid),    64'(c_ACC_ID));
            if (exp_valid && q.size() > 0) begin
                check("tdata", outStream_tdata,        q[0][63:0]);
                check("tlast", 64'(outStream_tlast),   64'(q[0][64]));
            end else begin
                check("tlast_idle", 64'(outStream_tlast), 64'd0);
            end
            if (rst) begin
                q.delete();
                m_count   = 0;
                m_payload = 0;
                m_rem     = 0;
                pkt_beats = 0;
            end else begin
                push = in_hs_ap_vld && exp_ack;
                pop  = exp_valid && outStream_tready;
                if (pop && q.size() > 0) begin
                    n_beats++;
                    pkt_beats++;
                    if (q[0][64]) begin
                        n_last++;
                        last_pkt_sz = pkt_beats;
                        pkt_beats   = 0;
                    end
                    void'(q.pop_front());
                end
                if (push) begin
                    if (!m_payload) begin
                        m_rem     = int'(in_hs[39:32]);
                        lst       = (m_rem == 0);
                        m_payload = (m_rem != 0);
                    end else begin
                        lst = (m_rem == 1);
                        m_rem--;
                        if (m_rem == 0) m_payload = 0;
                    end
                    q.push_back({lst, in_hs});
                end
                m_count = m_count + int'(push) - int'(pop);
            end
        end
    end

    function automatic logic [63:0] hdr(input logic [7:0] len, input logic [31:0] tag);
        return {24'h0, len, tag};
    endfunction

    task automatic send(input logic [63:0] d);
        bit acked;
        acked        = 0;
        in_hs        = d;
        in_hs_ap_vld = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_hs_ap_ack) begin
                acked = 1;
                break;
            end
        end
        if (!acked) check("send_ack_timeout", 64'(in_hs_ap_ack), 64'd1);
        @(posedge clk);
        #1;
        in_hs_ap_vld = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !outStream_tvalid) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 64'(outStream_tvalid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, l0;
        rst              = 1'b1;
        in_hs            = 64'h0;
        in_hs_ap_vld     = 1'b0;
        outStream_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        @(negedge clk);
        check("rst_ack",   64'(in_hs_ap_ack),     64'd0);
        check("rst_valid", 64'(outStream_tvalid), 64'd0);
        check("rst_busy",  64'(busy),             64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LEN=0 single-beat packet
        b0 = n_beats; l0 = n_last;
        send(64'h0000_0000_0000_00AA);
        drain();
        check("len0_beats", 64'(n_beats - b0), 64'd1);
        check("len0_lasts", 64'(n_last - l0),  64'd1);

        // LEN=3 streamed back-to-back
        b0 = n_beats;
        send(hdr(8'd3, 32'h1111));
        send(64'hA1);
        send(64'hA2);
        send(64'hA3);
        drain();
        check("len3_beats", 64'(n_beats - b0), 64'd4);
        check("len3_pkt",   64'(last_pkt_sz),  64'd4);

        // Backpressure: third word must wait for space
        outStream_tready = 1'b0;
        send(hdr(8'd2, 32'h2222));
        send(64'hB1);
        in_hs        = 64'hB2;
        in_hs_ap_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ack_low", 64'(in_hs_ap_ack),    64'd0);
            check("bp_head",    outStream_tdata,      hdr(8'd2, 32'h2222));
        end
        @(posedge clk);
        #1;
        outStream_tready = 1'b1;
        send(64'hB2);
        drain();
        check("bp_pkt", 64'(last_pkt_sz), 64'd3);

        // Two back-to-back packets: LEN=1 then LEN=0
        l0 = n_last;
        send(hdr(8'd1, 32'h3333));
        send(64'hC1);
        send(hdr(8'd0, 32'h4444));
        drain();
        check("b2b_lasts", 64'(n_last - l0), 64'd2);

        // Reset in the middle of a LEN=5 packet
        outStream_tready = 1'b0;
        send(hdr(8'd5, 32'h5555));
        send(64'hD1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(outStream_tvalid), 64'd0);
        check("mid_rst_busy",  64'(busy),             64'd0);
        outStream_tready = 1'b1;
        b0 = n_beats; l0 = n_last;
        @(posedge clk);
        #1;
        send(hdr(8'd0, 32'h6666));
        drain();
        check("post_rst_beats", 64'(n_beats - b0), 64'd1);
        check("post_rst_lasts", 64'(n_last - l0),  64'd1);

        // LEN=255: 256-beat packet, then a fresh header
        b0 = n_beats;
        send(hdr(8'd255, 32'h7777));
        for (int i = 1; i <= 255; i++) send(64'(i) | 64'hFF00_0000_0000_0000);
        drain();
        check("len255_pkt",   64'(last_pkt_sz),    64'd256);
        check("len255_beats", 64'(n_beats - b0),   64'd256);
        send(hdr(8'd0, 32'h8888));
        drain();
        check("after255_pkt", 64'(last_pkt_sz), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hs_to_stream_adapter.md
HS_TO_STREAM_ADAPTER -- requirements
Module: hs_to_stream_adapter

Interface
REQ-001 SHALL have parameter: ACC_ID, 8'h00, constant driven on outStream_tid.
REQ-002 SHALL have parameter: LEN_LSB, 32, LSB of the 8-bit payload-length field in a header word.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: in_hs  input  64  data word from accelerator ap_hs output.
REQ-006 SHALL have port: in_hs_ap_vld  input  1  in_hs valid.
REQ-007 SHALL have port: in_hs_ap_ack  output  1  word accepted this cycle when high together with vld.
REQ-008 SHALL have port: outStream_tdata  output  64  AXI-Stream data.
REQ-009 SHALL have port: outStream_tvalid  output  1  AXI-Stream valid.
REQ-010 SHALL have port: outStream_tready  input  1  AXI-Stream ready.
REQ-011 SHALL have port: outStream_tlast  output  1  last word of packet.
REQ-012 SHALL have port: outStream_tid  output  8  equals ACC_ID.
REQ-013 SHALL have port: busy  output  1  packet in progress or words buffered.

Function
REQ-014 SHALL buffer words in a 2-entry FIFO; each entry holds 64-bit data plus 1 tlast bit; occupancy count 0..2.
REQ-015 SHALL drive in_hs_ap_ack = !rst && count<2, with no combinational dependence on in_hs_ap_vld or outStream_tready.
REQ-016 SHALL push when in_hs_ap_vld && in_hs_ap_ack; SHALL pop when outStream_tvalid && outStream_tready.
REQ-017 SHALL drive outStream_tvalid = count!=0, with tdata/tlast from the head entry; head SHALL stay stable while tvalid && !tready.
REQ-018 SHALL, on simultaneous push and pop, leave count unchanged and preserve word order.
REQ-019 SHALL give 1-cycle latency: a word pushed in cycle N into an empty FIFO appears on tvalid in cycle N+1.
REQ-020 SHALL sustain one word per cycle when tready is held high.
REQ-021 SHALL track packets with FSM states HEADER and PAYLOAD plus an 8-bit remaining counter, updated on push only.
REQ-022 SHALL, on a push in HEADER, take LEN = in_hs[LEN_LSB+7:LEN_LSB]: if LEN==0, store tlast=1 and stay in HEADER; else store tlast=0, set remaining=LEN and go to PAYLOAD.
REQ-023 SHALL, on a push in PAYLOAD, store tlast = (remaining==1) and decrement remaining; when remaining==1, return to HEADER.
REQ-024 SHALL accept LEN=255 (packet of 256 words) without counter wrap.
REQ-025 SHALL drive busy = (state==PAYLOAD) || count!=0.
REQ-026 SHALL drive outStream_tid = ACC_ID at all times.

Reset
REQ-027 SHALL, while rst is high at a clock edge, set count=0, state=HEADER and remaining=0, discarding buffered words and any partial packet.
REQ-028 SHALL hold in_hs_ap_ack=0 combinationally while rst is high; after reset, tvalid=0, tlast=0, busy=0, and tdata is don't-care.
REQ-029 SHALL treat the first word accepted after reset as a header, even if reset occurred mid-packet.

Verification
REQ-030 SHALL cover: header LEN=0 (0x0000_0000_0000_00AA) with tready=1 -> one beat with tlast=1, tid=ACC_ID, 1-cycle latency.
REQ-031 SHALL cover: header LEN=3 plus 3 payload words streamed back-to-back with tready=1 -> 4 beats, tlast only on the 4th, ack high every cycle.
REQ-032 SHALL cover: tready=0 while 3 words are offered -> ack drops after 2 accepts, tdata stable; tready=1 -> words emerge in order, ack returns.
REQ-033 SHALL cover: two back-to-back packets (LEN=1, LEN=0) -> tlast on beats 2 and 3; busy falls 1 cycle after the last pop.
REQ-034 SHALL cover: rst pulse after the 2nd word of a LEN=5 packet -> tvalid=0, busy=0; next word with LEN=0 -> single beat with tlast=1.
REQ-035 SHALL cover: header LEN=255 -> tlast on beat 256 only; next word is treated as a header.
